// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register: handshaked word loads/stores, upstream stall,
// alignment check and bus-timeout abort.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        R31toReg,
    input  logic        JaltoReg,
    input  logic [31:0] RD2,
    input  logic [31:0] alu,
    input  logic [4:0]  mux,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        out_RegWrite,
    output logic        out_MemtoReg,
    output logic        out_R31toReg,
    output logic        out_JaltoReg,
    output logic [31:0] out_rdata,
    output logic [31:0] out_alu,
    output logic [4:0]  out_mux,
    output logic        out_misalign,
    output logic        out_bus_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;

    // EX/MEM snapshot taken when a request issues
    logic          snap_mw_q, snap_mr_q, snap_m2r_q, snap_rw_q, snap_r31_q, snap_jal_q;
    logic [31:0]   snap_alu_q;
    logic [4:0]    snap_mux_q;

    logic          mem_op, aligned, timeout;
    logic          issue, misalign, complete, abort;

    assign mem_op  = MemRead | MemWrite;
    assign aligned = (alu[1:0] == 2'b00);
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op && aligned)  state_d = WAIT;
            WAIT:    if (dm_ack || timeout)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack takes priority over timeout in the same cycle
    always_comb begin
        issue    = 1'b0;
        misalign = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                issue    = mem_op && aligned;
                misalign = mem_op && !aligned;
                stall    = issue;
            end
            WAIT: begin
                complete = dm_ack;
                abort    = !dm_ack && timeout;
                stall    = !dm_ack && !timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (issue) begin
            cnt_q <= '0;
        end else if (state_q == WAIT && stall) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else if (issue) begin
            dm_req   <= 1'b1;
            dm_we    <= MemWrite;
            dm_addr  <= {alu[31:2], 2'b00};
            dm_wdata <= RD2;
        end else if (complete || abort) begin
            dm_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_mw_q  <= 1'b0;
            snap_mr_q  <= 1'b0;
            snap_m2r_q <= 1'b0;
            snap_rw_q  <= 1'b0;
            snap_r31_q <= 1'b0;
            snap_jal_q <= 1'b0;
            snap_alu_q <= '0;
            snap_mux_q <= '0;
        end else if (issue) begin
            snap_mw_q  <= MemWrite;
            snap_mr_q  <= MemRead;
            snap_m2r_q <= MemtoReg;
            snap_rw_q  <= RegWrite;
            snap_r31_q <= R31toReg;
            snap_jal_q <= JaltoReg;
            snap_alu_q <= alu;
            snap_mux_q <= mux;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_RegWrite <= 1'b0;
            out_MemtoReg <= 1'b0;
            out_R31toReg <= 1'b0;
            out_JaltoReg <= 1'b0;
            out_rdata    <= '0;
            out_alu      <= '0;
            out_mux      <= '0;
            out_misalign <= 1'b0;
            out_bus_err  <= 1'b0;
        end else begin
            out_misalign <= 1'b0;
            out_bus_err  <= 1'b0;
            if (stall) begin
                // bubble: controls cleared, data held
                out_RegWrite <= 1'b0;
                out_MemtoReg <= 1'b0;
                out_R31toReg <= 1'b0;
                out_JaltoReg <= 1'b0;
            end else if (complete || abort) begin
                out_RegWrite <= snap_rw_q && complete;
                out_MemtoReg <= snap_m2r_q;
                out_R31toReg <= snap_r31_q;
                out_JaltoReg <= snap_jal_q;
                out_alu      <= snap_alu_q;
                out_mux      <= snap_mux_q;
                out_rdata    <= (complete && snap_mr_q && !snap_mw_q) ? dm_rdata : '0;
                out_bus_err  <= abort;
            end else begin
                out_RegWrite <= RegWrite && !misalign;
                out_MemtoReg <= MemtoReg;
                out_R31toReg <= R31toReg;
                out_JaltoReg <= JaltoReg;
                out_alu      <= alu;
                out_mux      <= mux;
                out_rdata    <= '0;
                out_misalign <= misalign;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations (TIMEOUT = 4).
module tb_mem_wb_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite, MemRead, MemtoReg, RegWrite, R31toReg, JaltoReg;
    logic [31:0] RD2, alu;
    logic [4:0]  mux;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall;
    logic        out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg;
    logic [31:0] out_rdata, out_alu;
    logic [4:0]  out_mux;
    logic        out_misalign, out_bus_err;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .R31toReg(R31toReg), .JaltoReg(JaltoReg),
        .RD2(RD2), .alu(alu), .mux(mux),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall),
        .out_RegWrite(out_RegWrite), .out_MemtoReg(out_MemtoReg),
        .out_R31toReg(out_R31toReg), .out_JaltoReg(out_JaltoReg),
        .out_rdata(out_rdata), .out_alu(out_alu), .out_mux(out_mux),
        .out_misalign(out_misalign), .out_bus_err(out_bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic mr, input logic m2r, input logic rw,
                         input logic r31, input logic jal, input logic [31:0] rd2,
                         input logic [31:0] a, input logic [4:0] m);
        MemWrite = mw; MemRead = mr; MemtoReg = m2r; RegWrite = rw;
        R31toReg = r31; JaltoReg = jal; RD2 = rd2; alu = a; mux = m;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dm_req"},   dm_req, 0);
        check({tag, " dm_we"},    dm_we, 0);
        check({tag, " dm_addr"},  dm_addr, 0);
        check({tag, " dm_wdata"}, dm_wdata, 0);
        check({tag, " ctrl"}, {out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg}, 0);
        check({tag, " rdata"},    out_rdata, 0);
        check({tag, " alu"},      out_alu, 0);
        check({tag, " mux"},      out_mux, 0);
        check({tag, " errs"},     {out_misalign, out_bus_err}, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        dm_ack = 1'b0; dm_rdata = 32'h0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // ALU op
        drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_1234, 5'd5);
        #1 check("alu stall", stall, 0);
        tick();
        check("alu out_alu", out_alu, 32'h1234);
        check("alu out_mux", out_mux, 5);
        check("alu RegWrite", out_RegWrite, 1);
        check("alu dm_req", dm_req, 0);

        // load 0x100, ack in fourth WAIT cycle (coincides with timeout count)
        drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0100, 5'd7);
        stall_cnt = 0;
        #1 check("ld issue stall", stall, 1);
        if (stall) stall_cnt++;
        tick();
        check("ld dm_req", dm_req, 1);
        check("ld dm_we", dm_we, 0);
        check("ld dm_addr", dm_addr, 32'h100);
        check("ld bubble RegWrite", out_RegWrite, 0);
        check("ld bubble alu hold", out_alu, 32'h1234);
        for (int i = 0; i < 4; i++) begin
            dm_ack   = (i == 3);
            dm_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h5555_AAAA;
            #1 check("ld wait stall", stall, (i == 3) ? 0 : 1);
            if (stall) stall_cnt++;
            check("ld wait req", dm_req, 1);
            tick();
        end
        check("ld stall cycles", stall_cnt, 4);
        check("ld rdata", out_rdata, 32'hDEAD_BEEF);
        check("ld MemtoReg", out_MemtoReg, 1);
        check("ld RegWrite", out_RegWrite, 1);
        check("ld mux", out_mux, 7);
        check("ld req low", dm_req, 0);

        // ack while idle is ignored
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        dm_ack = 1'b1; dm_rdata = 32'h1111_1111;
        #1 check("idle ack stall", stall, 0);
        tick();
        dm_ack = 1'b0;
        check("idle ack rdata", out_rdata, 0);
        check("idle ack req", dm_req, 0);
        check("ld one-cycle RegWrite", out_RegWrite, 0);

        // store 0x204, ack in first WAIT cycle
        drive(1, 0, 0, 0, 0, 0, 32'hCAFE_0001, 32'h0000_0204, 5'd0);
        stall_cnt = 0;
        #1 if (stall) stall_cnt++;
        tick();
        check("st dm_req", dm_req, 1);
        check("st dm_we", dm_we, 1);
        check("st dm_wdata", dm_wdata, 32'hCAFE_0001);
        check("st dm_addr", dm_addr, 32'h204);
        dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
        #1 check("st ack stall", stall, 0);
        if (stall) stall_cnt++;
        tick();
        dm_ack = 1'b0;
        check("st stall cycles", stall_cnt, 1);
        check("st rdata", out_rdata, 0);
        check("st req low", dm_req, 0);
        check("st alu", out_alu, 32'h204);

        // misaligned load
        drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0102, 5'd3);
        #1 check("mis stall", stall, 0);
        tick();
        check("mis pulse", out_misalign, 1);
        check("mis RegWrite", out_RegWrite, 0);
        check("mis MemtoReg", out_MemtoReg, 1);
        check("mis alu", out_alu, 32'h102);
        check("mis dm_req", dm_req, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        check("mis pulse end", out_misalign, 0);

        // timeout abort
        drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0300, 5'd9);
        dm_rdata = 32'hBAD0_BAD0;
        #1 check("to issue stall", stall, 1);
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            check("to req high", dm_req, 1);
            check("to stall", stall, (i == int'(TO) - 1) ? 0 : 1);
            check("to no err yet", out_bus_err, 0);
            tick();
        end
        check("to req low", dm_req, 0);
        check("to bus_err", out_bus_err, 1);
        check("to RegWrite", out_RegWrite, 0);
        check("to rdata", out_rdata, 0);
        check("to mux", out_mux, 9);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1 check("to stall after", stall, 0);
        tick();
        check("to bus_err end", out_bus_err, 0);

        // reset during second WAIT cycle
        drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_ABCD, 5'd4);
        tick();
        drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0400, 5'd6);
        tick();
        tick();
        check("rst pre req", dm_req, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("rst mid");
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        check("rst held RegWrite", out_RegWrite, 0);
        check("rst held req", dm_req, 0);
        rst = 1'b1;
        drive(0, 0, 0, 1, 1, 1, 32'h0, 32'h0000_0055, 5'd31);
        #1 check("post rst stall", stall, 0);
        tick();
        check("post rst alu", out_alu, 32'h55);
        check("post rst mux", out_mux, 31);
        check("post rst ctrl", {out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg}, 4'b1011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
